// File: rtl/nx_table_monitor_mbank.sv
// ---------------------------------------------------------------------------
// nx_table_monitor_mbank
//
// Purpose: ring of N_BANKS table banks between a table producer and the CSR
// block. The producer commits one bank per credit; banks are released
// (by a CSR write to IMRD_ADDRESS or by a hardware consumer) strictly in
// commit order. Tracks write/read bank pointers, occupancy, sticky
// overflow/underflow flags, and provides a one-cycle registered read port
// into the oldest committed bank.
//
// Optional feature: define TMON_TIMESTAMP_EN to add a free-running cycle
// counter whose value is captured per bank at commit and returned on rd_ts.
// Without it rd_ts is tied to zero.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   mode                   00/01 hold, 10 run, 11 synchronous init
//   credit_limit           max filled banks (0 or >N_BANKS means N_BANKS)
//   tmon_credit_used       producer commits wr_bank
//   tmon_credit_available  producer may commit this cycle
//   wr_bank                bank the producer is filling
//   table_data             flat bank/entry storage from the producer
//   wr_stb, reg_addr       CSR write; address IMRD_ADDRESS releases rd_bank
//   im_consumed            hardware consumer releases rd_bank
//   im_available           at least one committed bank pending
//   rd_bank                oldest committed bank
//   occupancy              committed-but-unreleased banks
//   rd_req, rd_addr        read entry rd_addr of rd_bank
//   rd_ack, rd_dat         read response, one cycle after rd_req
//   rd_ts                  commit timestamp of rd_bank
//   overflow, underflow    sticky error flags
// ---------------------------------------------------------------------------
module nx_table_monitor_mbank #(
    parameter int N_BANKS         = 2,
    parameter int N_BANK_ENTRIES  = 8,
    parameter int N_DATA_BITS     = 32,
    parameter int N_REG_ADDR_BITS = 16,
    parameter int IMRD_ADDRESS    = 0,
    parameter int N_TS_BITS       = 32,
    localparam int CW = $clog2(N_BANKS + 1),
    localparam int BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
    localparam int EW = (N_BANK_ENTRIES > 1) ? $clog2(N_BANK_ENTRIES) : 1,
    localparam int TW = N_BANKS * N_BANK_ENTRIES * N_DATA_BITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 mode,
    input  logic [CW-1:0]              credit_limit,
    input  logic                       tmon_credit_used,
    output logic                       tmon_credit_available,
    output logic [BW-1:0]              wr_bank,
    input  logic [TW-1:0]              table_data,
    input  logic                       wr_stb,
    input  logic [N_REG_ADDR_BITS-1:0] reg_addr,
    input  logic                       im_consumed,
    output logic                       im_available,
    output logic [BW-1:0]              rd_bank,
    output logic [CW-1:0]              occupancy,
    input  logic                       rd_req,
    input  logic [EW-1:0]              rd_addr,
    output logic                       rd_ack,
    output logic [N_DATA_BITS-1:0]     rd_dat,
    output logic [N_TS_BITS-1:0]       rd_ts,
    output logic                       overflow,
    output logic                       underflow
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [BW-1:0]          wr_bank_q, wr_bank_d;
    logic [BW-1:0]          rd_bank_q, rd_bank_d;
    logic [CW-1:0]          occ_q, occ_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic                   rd_ack_q;
    logic [N_DATA_BITS-1:0] rd_dat_q, rd_dat_d;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic          run, init;
    logic          release_w;
    logic          credit_ok;
    logic          commit_ok, rel_ok;
    logic [CW-1:0] eff_limit;
    logic [BW-1:0] rd_sel;

    assign run  = (mode == 2'b10);
    assign init = (mode == 2'b11);

    // CSR release and consumer release in the same cycle collapse to one.
    assign release_w = (wr_stb && (reg_addr == N_REG_ADDR_BITS'(IMRD_ADDRESS))) || im_consumed;

    always_comb begin
        eff_limit = credit_limit;
        if (credit_limit == '0 || credit_limit > CW'(N_BANKS))
            eff_limit = CW'(N_BANKS);
    end

    // Credit looks only at registered occupancy, so a release in the same
    // cycle never frees credit for a commit until the following cycle.
    assign credit_ok = run && (occ_q < eff_limit);
    assign commit_ok = tmon_credit_used && credit_ok;
    assign rel_ok    = release_w && run && (occ_q != '0);

    function automatic logic [BW-1:0] next_ptr(input logic [BW-1:0] p);
        return (p == BW'(N_BANKS - 1)) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        occ_d     = occ_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;

        if (init) begin
            wr_bank_d = '0;
            rd_bank_d = '0;
            occ_d     = '0;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
        end else if (run) begin
            if (commit_ok) wr_bank_d = next_ptr(wr_bank_q);
            if (rel_ok)    rd_bank_d = next_ptr(rd_bank_q);
            case ({commit_ok, rel_ok})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
            if (tmon_credit_used && !credit_ok)   ovf_d = 1'b1;
            if (release_w && (occ_q == '0))       unf_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read path: bank and table sampled in the request cycle. During init
    // the pointer register may not yet be cleared, so force bank 0.
    // ------------------------------------------------------------------
    assign rd_sel = init ? '0 : rd_bank_q;

    always_comb begin
        int unsigned base;
        base     = (32'(rd_sel) * 32'(N_BANK_ENTRIES) + 32'(rd_addr)) * 32'(N_DATA_BITS);
        rd_dat_d = '0;
        if (32'(rd_addr) < 32'(N_BANK_ENTRIES) && 32'(rd_sel) < 32'(N_BANKS))
            rd_dat_d = table_data[base +: N_DATA_BITS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= '0;
            rd_bank_q <= '0;
            occ_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_dat_q  <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            occ_q     <= occ_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            rd_ack_q  <= rd_req;
            if (rd_req) rd_dat_q <= rd_dat_d;
        end
    end

    // ------------------------------------------------------------------
    // Commit timestamps
    // ------------------------------------------------------------------
`ifdef TMON_TIMESTAMP_EN
    logic [N_TS_BITS-1:0]              ts_cnt_q;
    logic [N_BANKS-1:0][N_TS_BITS-1:0] ts_mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q <= '0;
            ts_mem_q <= '0;
        end else begin
            // Counter free-runs across init; only the stored stamps clear.
            ts_cnt_q <= ts_cnt_q + 1'b1;
            if (init)
                ts_mem_q <= '0;
            else if (commit_ok)
                ts_mem_q[wr_bank_q] <= ts_cnt_q;
        end
    end

    assign rd_ts = ts_mem_q[rd_bank_q];
`else
    assign rd_ts = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tmon_credit_available = credit_ok;
    assign im_available          = !init && (occ_q != '0);
    assign wr_bank               = wr_bank_q;
    assign rd_bank               = rd_bank_q;
    assign occupancy             = occ_q;
    assign overflow              = ovf_q;
    assign underflow             = unf_q;
    assign rd_ack                = rd_ack_q;
    assign rd_dat                = rd_dat_q;

endmodule

// File: tb/tb_nx_table_monitor_mbank.sv
// Bench for nx_table_monitor_mbank: three-bank ring with six entries per
// bank, so an out-of-range entry index is expressible on rd_addr.
module tb_nx_table_monitor_mbank;

    localparam int NB   = 3;
    localparam int NE   = 6;
    localparam int DW   = 32;
    localparam int RA   = 16;
    localparam int IMRD = 4;
    localparam int TSW  = 32;
    localparam int CW   = 2;
    localparam int BW   = 2;
    localparam int EW   = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode;
    logic [CW-1:0]     credit_limit;
    logic              tmon_credit_used;
    logic              tmon_credit_available;
    logic [BW-1:0]     wr_bank;
    logic [NB*NE*DW-1:0] table_data;
    logic              wr_stb;
    logic [RA-1:0]     reg_addr;
    logic              im_consumed;
    logic              im_available;
    logic [BW-1:0]     rd_bank;
    logic [CW-1:0]     occupancy;
    logic              rd_req;
    logic [EW-1:0]     rd_addr;
    logic              rd_ack;
    logic [DW-1:0]     rd_dat;
    logic [TSW-1:0]    rd_ts;
    logic              overflow;
    logic              underflow;

    nx_table_monitor_mbank #(
        .N_BANKS(NB), .N_BANK_ENTRIES(NE), .N_DATA_BITS(DW),
        .N_REG_ADDR_BITS(RA), .IMRD_ADDRESS(IMRD), .N_TS_BITS(TSW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .credit_limit(credit_limit),
        .tmon_credit_used(tmon_credit_used),
        .tmon_credit_available(tmon_credit_available),
        .wr_bank(wr_bank), .table_data(table_data), .wr_stb(wr_stb),
        .reg_addr(reg_addr), .im_consumed(im_consumed),
        .im_available(im_available), .rd_bank(rd_bank), .occupancy(occupancy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_dat(rd_dat),
        .rd_ts(rd_ts), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int b, input int e);
        return 32'hB000_0000 | (b << 8) | e;
    endfunction

    // Scoreboard of read responses.
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n && rd_ack) begin
            if (exp_q.size() == 0) chk("rd_ack_extra", 1, 0);
            else                   chk("rd_dat", rd_dat, exp_q.pop_front());
        end
    end

    // Reference cycle counter: edges since reset release.
    logic [31:0] tb_cyc;
    logic [31:0] ts_exp [NB];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 1;
    end

    function automatic logic [31:0] ts_want(input int b);
`ifdef TMON_TIMESTAMP_EN
        return ts_exp[b];
`else
        return (b < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ts_clear();
        for (int b = 0; b < NB; b++) ts_exp[b] = '0;
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'b00; credit_limit = '0; tmon_credit_used = 0;
        wr_stb = 0; reg_addr = '0; im_consumed = 0; rd_req = 0; rd_addr = '0;
        for (int b = 0; b < NB; b++)
            for (int e = 0; e < NE; e++)
                table_data[(b*NE+e)*DW +: DW] = pat(b, e);
        table_data[(2*NE+5)*DW +: DW] = 32'hDEADBEEF;
        ts_clear();

        #12;
        chk("rst_wr", wr_bank, 0);
        chk("rst_rd", rd_bank, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        chk("rst_ack", rd_ack, 0);
        chk("rst_dat", rd_dat, 0);
        chk("rst_ts", rd_ts, 0);
        @(negedge clk); rst_n = 1'b1;

        // Hold mode ignores everything and sets no flag.
        tmon_credit_used = 1; im_consumed = 1; tick();
        chk("hold_wr", wr_bank, 0);
        chk("hold_occ", occupancy, 0);
        chk("hold_ovf", overflow, 0);
        chk("hold_unf", underflow, 0);
        tmon_credit_used = 0; im_consumed = 0;

        // 1: fill ring, then overflow.
        mode = 2'b10; credit_limit = 0; #1;
        chk("cred_run", tmon_credit_available, 1);
        chk("avail_empty", im_available, 0);
        for (int i = 0; i < NB; i++) begin
            tmon_credit_used = 1; ts_exp[i] = tb_cyc; tick();
            chk("fill_wr", wr_bank, (i + 1) % NB);
            chk("fill_occ", occupancy, i + 1);
        end
        chk("full_cred", tmon_credit_available, 0);
        chk("full_avail", im_available, 1);
        chk("ts_b0", rd_ts, ts_want(0));
        tick();
        chk("ovf_set", overflow, 1);
        chk("ovf_wr", wr_bank, 0);
        chk("ovf_occ", occupancy, 3);
        chk("ovf_unf", underflow, 0);
        tmon_credit_used = 0;

        // 2: dual release sources count once; wrong address does nothing.
        wr_stb = 1; reg_addr = IMRD; im_consumed = 1; tick();
        chk("dual_rd", rd_bank, 1);
        chk("dual_occ", occupancy, 2);
        chk("ts_b1", rd_ts, ts_want(1));
        reg_addr = IMRD + 1; im_consumed = 0; tick();
        chk("badaddr_occ", occupancy, 2);
        chk("badaddr_rd", rd_bank, 1);
        wr_stb = 0;
        im_consumed = 1; tick();
        chk("rel_rd", rd_bank, 2);
        chk("rel_occ", occupancy, 1);

        // 3: simultaneous commit and release.
        tmon_credit_used = 1; im_consumed = 1; ts_exp[0] = tb_cyc; tick();
        chk("both_occ", occupancy, 1);
        chk("both_wr", wr_bank, 1);
        chk("both_rd", rd_bank, 0);
        chk("ts_b0b", rd_ts, ts_want(0));
        tmon_credit_used = 0; im_consumed = 0;

        // 4: limit 1.
        credit_limit = 1; #1;
        chk("lim_cred0", tmon_credit_available, 0);
        im_consumed = 1; tick();
        chk("lim_rd", rd_bank, 1);
        chk("lim_occ0", occupancy, 0);
        chk("lim_cred1", tmon_credit_available, 1);
        im_consumed = 0; tmon_credit_used = 1; ts_exp[1] = tb_cyc; tick();
        chk("lim_wr", wr_bank, 2);
        chk("lim_occ1", occupancy, 1);
        chk("lim_cred_lo", tmon_credit_available, 0);
        im_consumed = 1; tick();
        chk("lim_blk_occ", occupancy, 0);
        chk("lim_blk_wr", wr_bank, 2);
        chk("lim_blk_rd", rd_bank, 2);
        tmon_credit_used = 0; tick();
        chk("unf_set", underflow, 1);
        chk("unf_rd", rd_bank, 2);
        chk("unf_occ", occupancy, 0);
        im_consumed = 0; credit_limit = 0;

        // 5: reads from bank 2, back to back, including out-of-range entry.
        rd_req = 1; rd_addr = 5; exp_q.push_back(32'hDEADBEEF); tick();
        rd_addr = NE;            exp_q.push_back(32'h0);        tick();
        rd_addr = 0;             exp_q.push_back(pat(2, 0));    tick();
        rd_req = 0; tick();
        tmon_credit_used = 1; ts_exp[2] = tb_cyc; tick();
        tmon_credit_used = 0;
        // Release alongside a request: the data still comes from bank 2.
        rd_req = 1; rd_addr = 3; im_consumed = 1; exp_q.push_back(pat(2, 3)); tick();
        rd_req = 0; im_consumed = 0;
        chk("rdrel_rd", rd_bank, 0);
        chk("rdrel_occ", occupancy, 0);
        tick();

        // 6: init clears everything; reads bank 0 while rd_bank is 1.
        tmon_credit_used = 1;
        for (int i = 0; i < NB; i++) begin ts_exp[i] = tb_cyc; tick(); end
        tmon_credit_used = 0; im_consumed = 1; tick(); im_consumed = 0;
        chk("pre_init_occ", occupancy, 2);
        chk("pre_init_rd", rd_bank, 1);
        mode = 2'b11; rd_req = 1; rd_addr = 2; exp_q.push_back(pat(0, 2)); tick();
        rd_req = 0; ts_clear();
        chk("init_occ", occupancy, 0);
        chk("init_wr", wr_bank, 0);
        chk("init_rd", rd_bank, 0);
        chk("init_ovf", overflow, 0);
        chk("init_unf", underflow, 0);
        chk("init_avail", im_available, 0);
        chk("init_cred", tmon_credit_available, 0);
        chk("init_ts", rd_ts, 0);
        mode = 2'b10; tick();

        // Reset mid-read drops the ack at once.
        rd_req = 1; rd_addr = 1; exp_q.push_back(pat(0, 1)); tick();
        rst_n = 1'b0; rd_req = 0; #1;
        chk("midrst_ack", rd_ack, 0);
        chk("midrst_dat", rd_dat, 0);
        exp_q.delete(); ts_clear();
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("post_rst_wr", wr_bank, 0);
        chk("post_rst_ts", rd_ts, 0);

        // Timestamp counter restarts from reset.
        tmon_credit_used = 1; ts_exp[0] = tb_cyc; tick();
        tmon_credit_used = 0;
        chk("ts_restart", rd_ts, ts_want(0));
        chk("ts_occ", occupancy, 1);
        tick(); tick();

        chk("rd_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
